// File: rtl/square_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (square, sqrt).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package square_pkg;

    // Sequencing states of the iterative arithmetic blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand width and number of fraction bits in the operand.
    localparam int DEF_NBITS          = 8;
    localparam int DEF_HALF_PRECISION = 5;

endpackage

// File: rtl/square.sv
// Unsigned fixed-point squarer, shift-and-add, one multiplier bit per cycle.
// Latency: oValid rises NBITS+1 rising edges after the accepting edge, independent of data.
// Backpressure: one operation in flight; iReady low until the result is taken with oReady.
module square
    import square_pkg::*;
#(
    parameter int NBITS          = DEF_NBITS,
    parameter int HALF_PRECISION = DEF_HALF_PRECISION
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NBITS-1:0]   A,
    input  logic               iValid,
    output logic               iReady,
    output logic [2*NBITS-1:0] result,
    output logic               oValid,
    input  logic               oReady
);

    localparam int CW = $clog2(NBITS + 1);

    // The result carries 2*HALF_PRECISION fraction bits, which only makes
    // sense if the operand actually has that many fraction bits.
    if (HALF_PRECISION > NBITS) begin : g_bad_precision
        $error("square: HALF_PRECISION exceeds NBITS");
    end

    state_t               state;
    state_t               state_nxt;
    logic [2*NBITS-1:0]   mcand;
    logic [2*NBITS-1:0]   acc;
    logic [NBITS-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 finish;

    // State register; reset always returns to IDLE, aborting any operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs. BUSY spends NBITS cycles shifting and
    // one more cycle with the counter at zero, where the accumulator is
    // transferred to result. DONE returns to IDLE on the handshake edge, so a
    // new operand can only be taken the cycle after.
    always_comb begin
        state_nxt = state;
        iReady    = 1'b0;
        oValid    = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                iReady = ~reset;
                if (iValid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                oValid = 1'b1;
                if (oReady) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture A once at acceptance, then add the shifted multiplicand
    // for each set multiplier bit, LSB first. result only changes on completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                mcand  <= {{NBITS{1'b0}}, A};
                mplier <= A;
                acc    <= '0;
                cnt    <= CW'(NBITS);
            end else if (state == BUSY && cnt != '0) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end
            if (finish) begin
                result <= acc;
            end
        end
    end

endmodule

// File: tb/tb_square.sv
// Directed bench for square: vector table plus hand-written multi-cycle sequences.
// Latency: checks NBITS+1 edges from acceptance to oValid.
// Backpressure: exercises stalls with oReady low and iValid held during BUSY.
module tb_square;

    logic        clock;
    logic        reset;
    logic [7:0]  A;
    logic        iValid;
    logic        iReady;
    logic [15:0] result;
    logic        oValid;
    logic        oReady;

    int checks = 0;
    int errors = 0;

    square #(.NBITS(8), .HALF_PRECISION(5)) dut (
        .clock  (clock),
        .reset  (reset),
        .A      (A),
        .iValid (iValid),
        .iReady (iReady),
        .result (result),
        .oValid (oValid),
        .oReady (oReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] exp;
        int          stall;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full transaction: wait for iReady, present a, check latency, result,
    // stall behaviour and the state after the output handshake.
    task automatic run_op(input logic [7:0] a, input logic [15:0] exp,
                          input int stall, input string tag);
        int  n;
        bit  got;
        n = 0;
        while (!iReady && n < 20) begin
            tick();
            n++;
        end
        check({tag, " iReady before accept"}, iReady, 1);
        A      = a;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        A      = 8'($urandom);
        got = 0;
        n   = 0;
        while (!got && n < 30) begin
            tick();
            n++;
            if (oValid) got = 1;
        end
        check({tag, " latency"}, n, 9);
        check({tag, " result"}, result, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, " stall oValid"}, oValid, 1);
            check({tag, " stall result"}, result, exp);
            check({tag, " stall iReady"}, iReady, 0);
        end
        oReady = 1'b1;
        tick();
        oReady = 1'b0;
        check({tag, " oValid after handshake"}, oValid, 0);
        check({tag, " iReady after handshake"}, iReady, 1);
        check({tag, " result held"}, result, exp);
    endtask

    initial begin
        int diff;

        vecs[0] = '{8'h4E, 16'd6084,  0};
        vecs[1] = '{8'hFF, 16'd65025, 0};
        vecs[2] = '{8'h00, 16'd0,     0};
        vecs[3] = '{8'h20, 16'd1024,  0};
        vecs[4] = '{8'h01, 16'd1,     2};
        vecs[5] = '{8'h80, 16'd16384, 0};
        vecs[6] = '{8'h0F, 16'd225,   1};
        vecs[7] = '{8'hAA, 16'd28900, 5};
        vecs[8] = '{8'hC0, 16'd36864, 0};

        // Reset state.
        reset  = 1'b1;
        A      = 8'h00;
        iValid = 1'b0;
        oReady = 1'b0;
        #3;
        check("reset iReady", iReady, 0);
        check("reset oValid", oValid, 0);
        check("reset result", result, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("post-reset iReady", iReady, 1);
        check("post-reset oValid", oValid, 0);

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));
        end

        // iValid held with A changing throughout BUSY.
        A      = 8'h4E;
        iValid = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            check("busy iReady", iReady, 0);
            A = 8'($urandom);
            tick();
        end
        check("busy-ivalid oValid", oValid, 1);
        check("busy-ivalid result", result, 6084);
        oReady = 1'b1;
        tick();
        oReady = 1'b0;
        iValid = 1'b0;
        check("no accept on handshake iReady", iReady, 1);
        check("no accept on handshake oValid", oValid, 0);
        tick();
        check("still idle iReady", iReady, 1);

        // Reset in the 4th BUSY cycle.
        A      = 8'hFF;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid-busy reset iReady", iReady, 0);
        check("mid-busy reset oValid", oValid, 0);
        check("mid-busy reset result", result, 0);
        tick();
        reset = 1'b0;
        #1;
        check("mid-busy release iReady", iReady, 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("aborted oValid", oValid, 0);
        end
        run_op(8'h20, 16'd1024, 0, "after-abort");

        // Reset while in DONE.
        A      = 8'hFF;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        repeat (9) tick();
        check("pre-reset done oValid", oValid, 1);
        reset = 1'b1;
        #1;
        check("done reset oValid", oValid, 0);
        check("done reset result", result, 0);
        tick();
        reset = 1'b0;
        tick();
        check("done release iReady", iReady, 1);
        check("done release oValid", oValid, 0);

        // Loopback: sqrt(6) in Q3.5 is 2.449*32 = 78.4 -> 8'h4E.
        run_op(8'h4E, 16'd6084, 0, "loopback");
        diff = 6144 - int'(result);
        if (diff < 0) diff = -diff;
        check("loopback within tolerance", (diff <= 2048), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/square.md
SQUARE -- requirements
Module: square

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter HALF_PRECISION, default 5, giving the number of fraction bits in operand A.
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port A, input, NBITS bits: unsigned fixed-point operand with HALF_PRECISION fraction bits.
REQ-006 The block SHALL have port iValid, input, 1 bit: A is valid this cycle.
REQ-007 The block SHALL have port iReady, output, 1 bit: the block can accept an operand this cycle.
REQ-008 The block SHALL have port result, output, 2*NBITS bits: unsigned A*A with 2*HALF_PRECISION fraction bits.
REQ-009 The block SHALL have port oValid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port oReady, input, 1 bit: the consumer accepts result this cycle.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 In IDLE, the block SHALL drive iReady=1, oValid=0; all other states SHALL drive iReady=0.
REQ-013 An operand SHALL be accepted on a rising edge with iValid=1 and iReady=1: capture A into multiplicand and multiplier registers, clear accumulator, load bit counter with NBITS, go to BUSY.
REQ-014 A SHALL be sampled only at acceptance; later changes to A SHALL NOT affect the result.
REQ-015 Each BUSY cycle SHALL process one multiplier bit, LSB first: add the shifted multiplicand to the 2*NBITS-bit accumulator if the bit is 1; shift the multiplicand left by 1 and the multiplier right by 1; decrement the counter.
REQ-016 When the counter reaches 0, the FSM SHALL go to DONE; oValid SHALL rise exactly NBITS+1 rising edges after the accepting edge.
REQ-017 The accumulator SHALL be 2*NBITS bits, so no overflow or truncation occurs; result SHALL equal the exact product with no rounding.
REQ-018 In DONE, the block SHALL hold oValid=1 and a stable result until a rising edge with oReady=1, then go to IDLE.
REQ-019 result SHALL hold its last value after the handshake until the next completion; it is meaningful only while oValid=1.
REQ-020 A new operand SHALL NOT be accepted in the same cycle as the output handshake; iReady rises the cycle after.
REQ-021 The block SHALL ignore iValid in BUSY and DONE, and oReady in IDLE and BUSY.
REQ-022 A=0 SHALL still take the full NBITS BUSY cycles; latency is data-independent.

Reset
REQ-023 On reset assertion, the block SHALL asynchronously force state=IDLE, oValid=0, result=0, accumulator=0, counter=0, and iReady=1 once reset deasserts.
REQ-024 While reset is asserted, iReady SHALL be 0.
REQ-025 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no oValid pulse; the next operand after release SHALL compute correctly.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, BUSY, DONE) and default constants NBITS and HALF_PRECISION, shared with sqrt.
REQ-027 The counter width SHALL be $clog2(NBITS+1).
REQ-028 The block SHALL be a single module with no sub-module; the datapath and FSM are co-located.

Verification
REQ-029 A=8'h4E (2.4375), oReady=1 -> result=16'd6084 (5.9414 in Q6.10) with oValid 9 edges after acceptance.
REQ-030 A=8'hFF -> result=16'd65025; A=8'h00 -> result=0 with identical 9-edge latency.
REQ-031 oReady held 0 for 5 cycles in DONE -> oValid and result stay stable and iReady stays 0; oReady=1 -> IDLE next edge.
REQ-032 iValid held 1 with A changing every cycle during BUSY -> result reflects only the accepted A; no second acceptance until IDLE.
REQ-033 Reset pulsed in the 4th BUSY cycle -> oValid stays 0 and iReady=1 after release; following A=8'h20 -> result=16'd1024.
REQ-034 Loopback with sqrt: sqrt(6) output fed as A -> result within 2*2^HALF_PRECISION*2^HALF_PRECISION LSBs of 6<<(2*HALF_PRECISION).
